denorm: RTL

DENORM -- requirements
Module: denorm

---
 rtl/denorm_pkg.sv | 13 +
 rtl/denorm.sv | 103 ++++++++++
 2 files changed

// File: rtl/denorm_pkg.sv
// Shared defaults and FSM state type for the denormalizer.
package denorm_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_EXP_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/denorm.sv
// Denormalizer: right-shifts a normalized mantissa one bit per cycle until the
// leading one sits at its original position, tracking lost bits and overflow.
module denorm
    import denorm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mant,
    input  logic [EXP_W-1:0] square,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valout,
    output logic             inexact,
    output logic             ovf
);

    localparam logic [EXP_W:0] TOP = (EXP_W+1)'(WIDTH-1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic [EXP_W:0]   cnt;
    logic [EXP_W:0]   shamt;
    logic             accept, is_zero, is_ovf;

    assign accept  = in_valid && in_ready;
    assign is_zero = (mant == '0);
    assign is_ovf  = ({1'b0, square} > TOP);
    // Only meaningful when !is_ovf; wraps otherwise and is ignored.
    assign shamt   = TOP - {1'b0, square};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_zero || is_ovf || shamt == '0) state_nxt = DONE;
                    else                                  state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Counter reaches zero on this edge.
                if (cnt == (EXP_W+1)'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work    <= '0;
            cnt     <= '0;
            valout  <= '0;
            inexact <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work    <= mant;
                        inexact <= 1'b0;
                        ovf     <= 1'b0;
                        if (is_zero) begin
                            valout <= '0;
                            cnt    <= '0;
                        end else if (is_ovf) begin
                            valout <= '1;
                            ovf    <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            valout <= mant;
                            cnt    <= shamt;
                        end
                    end
                end
                SHIFT: begin
                    work    <= work >> 1;
                    inexact <= inexact | work[0];
                    cnt     <= cnt - (EXP_W+1)'(1);
                    if (cnt == (EXP_W+1)'(1)) valout <= work >> 1;
                end
                default: ;
            endcase
        end
    end

endmodule
